// File: rtl/red_pitaya_asg_sweep.sv
// red_pitaya_asg_sweep
// Frequency-sweep scheduler for one ASG channel. It walks the 64-bit phase-step
// word from a start value to a stop value in fixed increments and holds each
// value for a programmable dwell time. The outputs drive the channel's
// set_step_i / set_step_lo_i inputs.
// Optional feature: define ASG_SWEEP_PINGPONG_EN to make mode 2 a ping-pong
// sweep. When it is undefined, mode 2 behaves as repeat and the swap logic is
// not built.
module red_pitaya_asg_sweep #(
    parameter int DWW  = 32,
    parameter int CNTW = 16
) (
    input  logic            dac_clk_i,
    input  logic            dac_rstn_i,
    input  logic            cfg_en_i,
    input  logic            cfg_rst_i,
    input  logic            start_i,
    input  logic            pause_i,
    input  logic [63:0]     cfg_start_i,
    input  logic [63:0]     cfg_stop_i,
    input  logic [63:0]     cfg_inc_i,
    input  logic [DWW-1:0]  cfg_dwell_i,
    input  logic [1:0]      cfg_mode_i,
    output logic [31:0]     step_o,
    output logic [31:0]     step_lo_o,
    output logic            step_vld_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [CNTW-1:0] sweep_cnt_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state;

    // Shadow copies of the configuration, captured on an accepted start
    logic [63:0]     sh_start;
    logic [63:0]     sh_stop;
    logic [63:0]     sh_inc;
    logic [DWW-1:0]  sh_dwell;
    logic [1:0]      sh_mode;
    logic            up;

    logic [63:0]     step;
    logic [DWW-1:0]  dwell_cnt;
    logic            step_vld;
    logic            done;
    logic [CNTW-1:0] sweep_cnt;

    // Derived next-state values
    logic [DWW-1:0]  dwell_ini;
    logic [DWW-1:0]  dwell_rel;
    logic [64:0]     next_sum;
    logic            clamp;
    logic [63:0]     step_adv;
    logic            at_stop;
    logic            is_rep;
`ifdef ASG_SWEEP_PINGPONG_EN
    logic            is_pp;
`endif

    // Saturating increment of the completed-sweep counter
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (&v)
            return v;
        return v + CNTW'(1);
    endfunction

    // A dwell of 0 is treated as 1, so the reload value never underflows
    function automatic logic [DWW-1:0] dwell_load(input logic [DWW-1:0] d);
        if (d == '0)
            return '0;
        return d - DWW'(1);
    endfunction

    // Next step value: 65-bit add/sub so carry or borrow flags a wrap, then clamp to stop
    always_comb begin
        dwell_ini = dwell_load(cfg_dwell_i);
        dwell_rel = dwell_load(sh_dwell);
        next_sum  = '0;
        clamp     = 1'b0;
        if (up) begin
            next_sum = {1'b0, step} + {1'b0, sh_inc};
            clamp    = (sh_inc == 64'd0) || next_sum[64] || (next_sum[63:0] >= sh_stop);
        end else begin
            next_sum = {1'b0, step} - {1'b0, sh_inc};
            clamp    = (sh_inc == 64'd0) || next_sum[64] || (next_sum[63:0] <= sh_stop);
        end
        step_adv = clamp ? sh_stop : next_sum[63:0];
        at_stop  = (step == sh_stop);
`ifdef ASG_SWEEP_PINGPONG_EN
        is_rep   = (sh_mode == 2'd1);
        is_pp    = (sh_mode == 2'd2);
`else
        is_rep   = (sh_mode == 2'd1) || (sh_mode == 2'd2);
`endif
    end

    // Sweep sequencer: IDLE/RUN/HOLD with registered step, pulses and counter
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state     <= ST_IDLE;
            sh_start  <= '0;
            sh_stop   <= '0;
            sh_inc    <= '0;
            sh_dwell  <= '0;
            sh_mode   <= '0;
            up        <= 1'b0;
            step      <= '0;
            dwell_cnt <= '0;
            step_vld  <= 1'b0;
            done      <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            step_vld <= 1'b0;
            done     <= 1'b0;
            if (cfg_rst_i) begin
                state     <= ST_IDLE;
                step      <= '0;
                sweep_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i && cfg_en_i) begin
                            sh_start  <= cfg_start_i;
                            sh_stop   <= cfg_stop_i;
                            sh_inc    <= cfg_inc_i;
                            sh_dwell  <= cfg_dwell_i;
                            sh_mode   <= cfg_mode_i;
                            up        <= (cfg_stop_i >= cfg_start_i);
                            step      <= cfg_start_i;
                            step_vld  <= 1'b1;
                            dwell_cnt <= dwell_ini;
                            state     <= ST_RUN;
                        end
                    end
                    ST_RUN, ST_HOLD: begin
                        // A paused cycle freezes everything; the first unpaused
                        // cycle counts as a normal run cycle so the delay equals
                        // the number of paused cycles.
                        if (pause_i) begin
                            state <= ST_HOLD;
                        end else begin
                            state <= ST_RUN;
                            if (dwell_cnt != '0) begin
                                dwell_cnt <= dwell_cnt - DWW'(1);
                            end else if (!at_stop) begin
                                step      <= step_adv;
                                step_vld  <= 1'b1;
                                dwell_cnt <= dwell_rel;
                            end else begin
                                sweep_cnt <= sat_inc(sweep_cnt);
                                if (is_rep) begin
                                    step      <= sh_start;
                                    step_vld  <= 1'b1;
                                    dwell_cnt <= dwell_rel;
                                end
`ifdef ASG_SWEEP_PINGPONG_EN
                                else if (is_pp) begin
                                    // Turnaround: stop becomes the new start; the
                                    // step already holds it, so no valid pulse.
                                    sh_start  <= sh_stop;
                                    sh_stop   <= sh_start;
                                    up        <= ~up;
                                    dwell_cnt <= dwell_rel;
                                end
`endif
                                else begin
                                    done  <= 1'b1;
                                    state <= ST_IDLE;
                                end
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign step_o      = step[63:32];
    assign step_lo_o   = step[31:0];
    assign step_vld_o  = step_vld;
    assign done_o      = done;
    assign sweep_cnt_o = sweep_cnt;
    assign state_o     = state;
    assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// tb_red_pitaya_asg_sweep
// Directed-vector bench for the ASG sweep scheduler.
module tb_red_pitaya_asg_sweep;

    localparam int DWW  = 32;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic            cfg_en;
    logic            cfg_rst;
    logic            start;
    logic            pause;
    logic [63:0]     cfg_start;
    logic [63:0]     cfg_stop;
    logic [63:0]     cfg_inc;
    logic [DWW-1:0]  cfg_dwell;
    logic [1:0]      cfg_mode;
    logic [31:0]     step_hi;
    logic [31:0]     step_lo;
    logic            step_vld;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] sweep_cnt;
    logic [1:0]      state;

    int errors = 0;
    int checks = 0;
    logic [63:0] seq [8];

    red_pitaya_asg_sweep #(.DWW(DWW), .CNTW(CNTW)) dut (
        .dac_clk_i   (clk),
        .dac_rstn_i  (rstn),
        .cfg_en_i    (cfg_en),
        .cfg_rst_i   (cfg_rst),
        .start_i     (start),
        .pause_i     (pause),
        .cfg_start_i (cfg_start),
        .cfg_stop_i  (cfg_stop),
        .cfg_inc_i   (cfg_inc),
        .cfg_dwell_i (cfg_dwell),
        .cfg_mode_i  (cfg_mode),
        .step_o      (step_hi),
        .step_lo_o   (step_lo),
        .step_vld_o  (step_vld),
        .busy_o      (busy),
        .done_o      (done),
        .sweep_cnt_o (sweep_cnt),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cur();
        return {step_hi, step_lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [63:0] s, input logic [63:0] p, input logic [63:0] i,
                         input logic [DWW-1:0] d, input logic [1:0] m);
        cfg_start = s;
        cfg_stop  = p;
        cfg_inc   = i;
        cfg_dwell = d;
        cfg_mode  = m;
    endtask

    // Start pulse sampled on the next edge; returns 1 time unit after that edge
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear();
        cfg_rst = 1'b1;
        tick();
        cfg_rst = 1'b0;
    endtask

    // Follow n step values spaced 'gap' cycles apart, starting just after the first load
    task automatic follow(input string tag, input int gap, input int n);
        chk($sformatf("%s v0", tag), cur(), seq[0]);
        chk($sformatf("%s vld0", tag), {63'd0, step_vld}, 64'd1);
        for (int i = 1; i < n; i++) begin
            repeat (gap - 1) tick();
            if (gap > 1)
                chk($sformatf("%s hold%0d", tag, i), {63'd0, step_vld}, 64'd0);
            tick();
            chk($sformatf("%s v%0d", tag, i), cur(), seq[i]);
            chk($sformatf("%s vld%0d", tag, i), {63'd0, step_vld}, 64'd1);
        end
    endtask

    initial begin
        rstn = 1'b0; cfg_en = 1'b1; cfg_rst = 1'b0; start = 1'b0; pause = 1'b0;
        setup(64'd0, 64'd0, 64'd0, 32'd0, 2'd0);
        #12;
        chk("rst step", cur(), 64'd0);
        chk("rst state", {62'd0, state}, 64'd0);
        chk("rst outs", {60'd0, busy, done, step_vld, |sweep_cnt}, 64'd0);
        rstn = 1'b1;
        tick();

        // Single ascending sweep
        setup(64'd100, 64'd130, 64'd10, 32'd3, 2'd0);
        seq = '{64'd100, 64'd110, 64'd120, 64'd130, 64'd0, 64'd0, 64'd0, 64'd0};
        kick();
        chk("asc busy", {63'd0, busy}, 64'd1);
        chk("asc state", {62'd0, state}, 64'd1);
        follow("asc", 3, 4);
        repeat (2) tick();
        chk("asc early done", {63'd0, done}, 64'd0);
        tick();
        chk("asc done", {63'd0, done}, 64'd1);
        chk("asc idle", {62'd0, state}, 64'd0);
        chk("asc final", cur(), 64'd130);
        chk("asc cnt", {48'd0, sweep_cnt}, 64'd1);
        tick();
        chk("asc done pulse", {63'd0, done}, 64'd0);
        chk("asc hold step", cur(), 64'd130);
        clear();

        // Overshoot clamp
        setup(64'd100, 64'd125, 64'd10, 32'd1, 2'd0);
        seq = '{64'd100, 64'd110, 64'd120, 64'd125, 64'd0, 64'd0, 64'd0, 64'd0};
        kick();
        follow("clamp", 1, 4);
        tick();
        chk("clamp done", {63'd0, done}, 64'd1);

        // Descending sweep
        setup(64'd130, 64'd100, 64'd20, 32'd1, 2'd3);
        seq = '{64'd130, 64'd110, 64'd100, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        kick();
        follow("desc", 1, 3);
        tick();
        chk("desc done", {63'd0, done}, 64'd1);

        // Carry from low word into high word
        setup(64'h1_FFFF_FFF0, 64'h2_0000_0030, 64'h20, 32'd1, 2'd0);
        seq = '{64'h1_FFFF_FFF0, 64'h2_0000_0010, 64'h2_0000_0030, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        kick();
        follow("carry", 1, 3);
        chk("carry hi", {32'd0, step_hi}, 64'd2);
        tick();

        // 64-bit overflow clamps to stop
        setup(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h20, 32'd1, 2'd0);
        seq = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        kick();
        follow("ovf", 1, 2);
        tick();
        chk("ovf done", {63'd0, done}, 64'd1);
        clear();

        // Repeat mode, then abort mid-sweep
        setup(64'd0, 64'd20, 64'd10, 32'd2, 2'd1);
        seq = '{64'd0, 64'd10, 64'd20, 64'd0, 64'd10, 64'd0, 64'd0, 64'd0};
        kick();
        follow("rep", 2, 5);
        chk("rep cnt", {48'd0, sweep_cnt}, 64'd1);
        cfg_rst = 1'b1;
        tick();
        cfg_rst = 1'b0;
        chk("abort state", {62'd0, state}, 64'd0);
        chk("abort step", cur(), 64'd0);
        chk("abort cnt", {48'd0, sweep_cnt}, 64'd0);
        chk("abort pulses", {62'd0, done, step_vld}, 64'd0);
        tick();
        chk("abort stays idle", {62'd0, state}, 64'd0);
        chk("abort no done", {63'd0, done}, 64'd0);

        // Mode 2
        setup(64'd0, 64'd20, 64'd10, 32'd2, 2'd2);
        seq = '{64'd0, 64'd10, 64'd20, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        kick();
        follow("m2", 2, 3);
        repeat (2) tick();
`ifdef ASG_SWEEP_PINGPONG_EN
        chk("pp turn step", cur(), 64'd20);
        chk("pp turn vld", {63'd0, step_vld}, 64'd0);
        chk("pp turn cnt", {48'd0, sweep_cnt}, 64'd1);
        repeat (2) tick();
        chk("pp down1", cur(), 64'd10);
        chk("pp down1 vld", {63'd0, step_vld}, 64'd1);
        repeat (2) tick();
        chk("pp down2", cur(), 64'd0);
        repeat (2) tick();
        chk("pp turn2 step", cur(), 64'd0);
        chk("pp turn2 vld", {63'd0, step_vld}, 64'd0);
        chk("pp turn2 cnt", {48'd0, sweep_cnt}, 64'd2);
        repeat (2) tick();
        chk("pp up1", cur(), 64'd10);
`else
        chk("m2rep wrap", cur(), 64'd0);
        chk("m2rep vld", {63'd0, step_vld}, 64'd1);
        chk("m2rep cnt", {48'd0, sweep_cnt}, 64'd1);
        repeat (2) tick();
        chk("m2rep next", cur(), 64'd10);
`endif
        clear();

        // Pause for 5 cycles mid-dwell, then an ignored start
        setup(64'd0, 64'd30, 64'd10, 32'd4, 2'd0);
        kick();
        chk("pause v0", cur(), 64'd0);
        repeat (2) tick();
        pause = 1'b1;
        tick();
        chk("pause state", {62'd0, state}, 64'd2);
        chk("pause busy", {63'd0, busy}, 64'd1);
        repeat (4) tick();
        chk("pause frozen", cur(), 64'd0);
        chk("pause state end", {62'd0, state}, 64'd2);
        pause = 1'b0;
        tick();
        chk("pause resumed", {62'd0, state}, 64'd1);
        chk("pause not yet", cur(), 64'd0);
        tick();
        chk("pause v1", cur(), 64'd10);
        chk("pause v1 vld", {63'd0, step_vld}, 64'd1);
        cfg_start = 64'd500;
        cfg_stop  = 64'd900;
        kick();
        chk("ign start step", cur(), 64'd10);
        chk("ign start vld", {63'd0, step_vld}, 64'd0);
        repeat (3) tick();
        chk("ign start v2", cur(), 64'd20);
        clear();

        // inc = 0 jumps straight to stop
        setup(64'd5, 64'd9, 64'd0, 32'd1, 2'd0);
        seq = '{64'd5, 64'd9, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        kick();
        follow("inc0", 1, 2);
        tick();
        chk("inc0 done", {63'd0, done}, 64'd1);

        // dwell = 0 behaves as dwell = 1
        setup(64'd0, 64'd20, 64'd10, 32'd0, 2'd0);
        seq = '{64'd0, 64'd10, 64'd20, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        kick();
        follow("dw0", 1, 3);
        tick();
        chk("dw0 done", {63'd0, done}, 64'd1);
        chk("dw0 cnt", {48'd0, sweep_cnt}, 64'd2);

        // Asynchronous reset mid-dwell, away from any clock edge
        setup(64'd100, 64'd200, 64'd10, 32'd10, 2'd0);
        kick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst step", cur(), 64'd0);
        chk("arst state", {62'd0, state}, 64'd0);
        chk("arst cnt", {48'd0, sweep_cnt}, 64'd0);
        chk("arst flags", {61'd0, busy, done, step_vld}, 64'd0);
        #2;
        rstn = 1'b1;
        tick();
        chk("arst idle", {62'd0, state}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/red_pitaya_asg_sweep.md
# red_pitaya_asg_sweep

Frequency-sweep scheduler for one ASG channel. It sequences the channel's 64-bit phase-step word (`step` high word plus `step_lo` low word) from a start value to a stop value in fixed increments. Each value is held for a programmable dwell time. Outputs feed the channel's `set_step_i` / `set_step_lo_i` inputs and are updated from the register bank through the `cfg_*` inputs.

## Interface
Parameters:
- `DWW`, default 32: dwell counter width (cycles).
- `CNTW`, default 16: completed-sweep counter width.

Ports:
- `dac_clk_i`  in  1  DAC clock; the only clock.
- `dac_rstn_i`  in  1  reset, asynchronous, active-low.
- `cfg_en_i`  in  1  sweep enable; start requests are ignored while low.
- `cfg_rst_i`  in  1  synchronous abort to IDLE; highest priority.
- `start_i`  in  1  start pulse (sw or trigger).
- `pause_i`  in  1  freezes the dwell counter while high.
- `cfg_start_i`  in  64  first step value, {hi,lo}.
- `cfg_stop_i`  in  64  final step value.
- `cfg_inc_i`  in  64  increment magnitude.
- `cfg_dwell_i`  in  DWW  cycles per step value; 0 is treated as 1.
- `cfg_mode_i`  in  2  0 = single, 1 = repeat, 2 = ping-pong, 3 = single.
- `step_o`  out  32  step high word.
- `step_lo_o`  out  32  step low word.
- `step_vld_o`  out  1  one-cycle pulse when the step outputs change.
- `busy_o`  out  1  high in RUN and HOLD.
- `done_o`  out  1  one-cycle pulse at the end of a single sweep.
- `sweep_cnt_o`  out  CNTW  completed sweeps; saturates at all-ones.
- `state_o`  out  2  0 = IDLE, 1 = RUN, 2 = HOLD.

## Operation
Reset values:
- All outputs 0; state IDLE.
- Shadow registers and the dwell counter are 0.

IDLE:
- Step outputs hold their last value.
- `start_i && cfg_en_i` does all of the following on the same clock edge:
  - Latches `cfg_start/stop/inc/dwell/mode` into shadow registers.
  - Sets the direction: `up = (stop >= start)`, unsigned 64-bit compare.
  - Loads `step = start` and pulses `step_vld_o`.
  - Loads `dwell_cnt = max(dwell,1) - 1` and moves to RUN.
- After the latch, changes on the `cfg_*` inputs have no effect until the next start.

RUN:
- Each cycle with `!pause_i`, decrement `dwell_cnt`.
- While `pause_i` is high, move to HOLD.
- When `dwell_cnt == 0` and the current step is not equal to the shadow stop value:
  - Compute `next = step ± inc` in 65 bits.
  - If `next` passes or reaches stop, or overflows/underflows, or `inc == 0`, then `step = stop`.
  - Otherwise `step = next`.
  - Pulse `step_vld_o` and reload `dwell_cnt`.
- When `dwell_cnt == 0` and `step == stop` (end of the stop dwell):
  - Increment `sweep_cnt_o`.
  - Mode 0/3: pulse `done_o`, go to IDLE, hold the step at stop.
  - Mode 1: `step = start`, pulse `step_vld_o`, reload `dwell_cnt`.
  - Mode 2: swap the shadow start and stop, invert `up`, reload `dwell_cnt`. The next value is the first increment in the new direction; no `step_vld_o` pulse at the turnaround.

HOLD:
- Outputs and `dwell_cnt` are frozen.
- Returns to RUN on the first cycle with `pause_i` low.

Other rules:
- `cfg_rst_i` in any state: IDLE next cycle, step outputs 0, `sweep_cnt_o` 0, no `done_o`, no `step_vld_o`.
- `start_i` in RUN or HOLD is ignored; no restart.
- Clearing `cfg_en_i` mid-sweep does not abort; only `cfg_rst_i` does.
- `start == stop`: one value for one dwell, then end-of-sweep handling.

## Timing
- Start to first step: 1 cycle. `start_i` high at edge T gives `step_o` valid after T, with `step_vld_o` high during cycle T+1.
- Step spacing: successive values exactly `max(dwell,1)` cycles apart, excluding paused cycles.
- `done_o`, the `sweep_cnt_o` increment and the IDLE entry happen in the cycle that would otherwise be the next step update.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Asynchronous reset takes effect immediately, mid-sweep included.

## Configuration
- Macro: `ASG_SWEEP_PINGPONG_EN`.
- Defined: mode 2 is ping-pong as described above.
- Undefined:
  - Mode 2 behaves as mode 1 (repeat).
  - The swap and direction-invert logic is not synthesized.
  - All other behaviour is unchanged.

## Test plan
- Single ascending: start=100, stop=130, inc=10, dwell=3, mode 0, `start_i` at T.
  - `step_o` = 100/110/120/130 at T+1/T+4/T+7/T+10.
  - `done_o` at T+13, then IDLE with step 130 and `sweep_cnt_o` = 1.
- Overshoot clamp and descent:
  - start=100, stop=125, inc=10 gives 100, 110, 120, 125.
  - start=130, stop=100, inc=20 gives 130, 110, 100.
- Repeat and ping-pong: start=0, stop=20, inc=10, dwell=2.
  - Mode 1 sequence: 0, 10, 20, 0, 10, …
  - Mode 2 with `ASG_SWEEP_PINGPONG_EN` defined: 0, 10, 20, 10, 0, 10, …
  - Mode 2 with the macro undefined: same as mode 1.
  - `sweep_cnt_o` increments once per stop-dwell end.
- Pause and ignored start: with dwell=4, hold `pause_i` high for 5 cycles mid-dwell.
  - The next step is delayed by exactly 5 cycles; `state_o` = 2 while paused.
  - A `start_i` issued during RUN changes nothing.
- Abort and edge cases:
  - `cfg_rst_i` mid-sweep: state 0, step 0, count 0, no `done_o`.
  - inc=0 with start=5, stop=9: 5 then 9.
  - dwell=0 behaves as dwell=1.
  - Asynchronous `dac_rstn_i` low mid-dwell clears all outputs without waiting for a clock edge.
